logic16_arbiter: RTL and testbench
==================================

Name: logic16_arbiter

Overview:
- Shares one 16-bit bitwise logic unit between two requesters. The unit's AND path is built on the existing 16-bit AND datapath.
- Each requester presents operands and an opcode through a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle. The result is registered into a single output slot with a valid/ready handshake.
- Sits between CPU-side clients (e.g. ALU sequencer, DMA test engine) and the shared logic datapath.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  16  requester 0 operand A
- req0_b  input  16  requester 0 operand B
- req0_op  input  2  requester 0 opcode
- req1_valid  input  1  requester 1 presents an operation
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_a  input  16  requester 1 operand A
- req1_b  input  16  requester 1 operand B
- req1_op  input  2  requester 1 opcode
- out_valid  output  1  result slot holds a result
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  16  registered result
- out_id  output  1  requester index that produced out_data
- ops_done  output  CNT_W  count of results consumed (out_valid && out_ready), wraps modulo 2^CNT_W

Behaviour:
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND. All operations are bitwise over 16 bits; there is no carry and no flags.
- Slot free condition: free = !out_valid || out_ready. The slot accepts a new result in the same cycle the old one drains, so one op per cycle is sustainable.
- Grant rules:
  - Arbitration is combinational.
  - If free is 0, no grant.
  - If exactly one req valid, grant it.
  - If both valid, grant the requester that was not granted most recently (last_gnt register).
- Ready signals: reqN_ready = grant to N. Ready may depend on valid; requesters must not wait for ready before asserting valid.
- Transfer: accept occurs when reqN_valid && reqN_ready. On that edge:
  - out_data <= f(op, a, b)
  - out_id <= N
  - out_valid <= 1
  - last_gnt <= N
- Latency: exactly 1 cycle from accept edge to out_valid visible.
- Drain: if out_valid && out_ready with no new accept in that cycle, out_valid <= 0 and out_data/out_id hold their last value.
- Hold: while out_valid && !out_ready, out_data and out_id are stable and both ready outputs are 0.
- ops_done increments on each out_valid && out_ready cycle and wraps from all-ones to 0.
- Simultaneous drain and accept in the same cycle: ops_done +1, the new result is loaded, out_valid stays 1.
- Reset state: out_valid 0, out_data 0, out_id 0, ops_done 0, last_gnt 1 (requester 0 wins the first contended cycle).
  - req0_ready and req1_ready are 0 while reset is high, regardless of other inputs.
- Reset mid-operation: any pending result is discarded, with no drain and no counter increment. Operation resumes from the reset state on the first cycle after reset deasserts.
- Requester inputs are only sampled on an accept cycle. Changing a, b or op while not granted has no effect.

Decomposition:
- Shared package (logic16_pkg):
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11
  - WIDTH=16
- Sub-module logic16_unit (combinational): inputs a, b, op; output result.
  - Built from the existing 16-bit gate modules (AND path on the 16-bit AND block, NAND as its inversion, OR/XOR from their 16-bit counterparts).
- Arbiter, output slot and counter live in logic16_arbiter.

Test Plan:
- Reset then idle: hold reset 2 cycles, release, no valids -> out_valid 0, out_data 0, ops_done 0, both readies 0.
- Single requester, each opcode: req0 a=16'hF0F0 b=16'hFF00, op 00/01/10/11 over four cycles with out_ready=1 -> out_data 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, each one cycle after accept, out_id 0, ops_done 4.
- Contention round-robin: both valid continuously, out_ready=1 -> grants alternate 0,1,0,1 starting with 0; out_id sequence 0,1,0,1; one accept per cycle.
- Backpressure: out_ready=0 with one result held -> both readies 0, out_data stable for 5 cycles. Raise out_ready with req1 valid -> same cycle drain and accept, out_valid stays 1, ops_done +1.
- Reset mid-operation: result pending (out_valid=1, out_ready=0), assert reset 1 cycle -> out_valid 0, ops_done 0, last_gnt=1. Next contended cycle grants requester 0.
- Counter wrap: with CNT_W=4, consume 17 results -> ops_done reads 1.

Source files
------------

// File: rtl/logic16_pkg.sv
// Shared definitions for the 16-bit shared logic unit and its arbiter.
// Opcode encodings, requester identifiers and the fixed datapath width.
package logic16_pkg;

    localparam int unsigned WIDTH = 16;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_e;

endpackage : logic16_pkg

// File: rtl/logic16_arbiter_if.sv
// Requester, result and counter signals of logic16_arbiter.
// slave is the arbiter's view; master is the client/consumer view.
interface logic16_arbiter_if
    import logic16_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic [CNT_W-1:0] ops_done;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id, ops_done
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id, ops_done
    );

endinterface : logic16_arbiter_if

// File: rtl/logic16_unit.sv
// Combinational 16-bit bitwise logic unit built from the 16-bit gate blocks.
// NAND reuses the AND block output rather than a separate gate array.
module and16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a & i_b;
endmodule : and16

module or16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a | i_b;
endmodule : or16

module xor16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a ^ i_b;
endmodule : xor16

module logic16_unit
    import logic16_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;

    and16 u_and16 (.i_a(i_a), .i_b(i_b), .o_y(w_and));
    or16  u_or16  (.i_a(i_a), .i_b(i_b), .o_y(w_or));
    xor16 u_xor16 (.i_a(i_a), .i_b(i_b), .o_y(w_xor));

    always_comb begin
        o_result = w_and;
        case (op_e'(i_op))
            OP_AND:  o_result = w_and;
            OP_OR:   o_result = w_or;
            OP_XOR:  o_result = w_xor;
            OP_NAND: o_result = ~w_and;
            default: o_result = w_and;
        endcase
    end

endmodule : logic16_unit

// File: rtl/logic16_arbiter.sv
// Two-requester round-robin front end for the shared 16-bit logic unit,
// with a single registered result slot and a completed-operation counter.
module logic16_arbiter
    import logic16_pkg::*;
#(
    parameter int unsigned WIDTH = logic16_pkg::WIDTH,
    parameter int unsigned CNT_W = 16
)(
    input  logic               clk,
    input  logic               reset,
    logic16_arbiter_if.slave   bus
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    req_e             r_out_id;
    req_e             r_last_gnt;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_free;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_drain;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [1:0]       w_sel_op;
    logic [WIDTH-1:0] w_result;

    // The slot can take a new result in the same cycle the old one drains.
    always_comb begin
        w_free   = !r_out_valid || bus.out_ready;
        w_drain  = r_out_valid && bus.out_ready;
        w_gnt0   = !reset && w_free && bus.req0_valid &&
                   (!bus.req1_valid || (r_last_gnt == REQ1));
        w_gnt1   = !reset && w_free && bus.req1_valid &&
                   (!bus.req0_valid || (r_last_gnt == REQ0));
        w_accept = w_gnt0 || w_gnt1;
        w_sel_a  = w_gnt1 ? bus.req1_a  : bus.req0_a;
        w_sel_b  = w_gnt1 ? bus.req1_b  : bus.req0_b;
        w_sel_op = w_gnt1 ? bus.req1_op : bus.req0_op;
    end

    logic16_unit u_unit (
        .i_a      (w_sel_a),
        .i_b      (w_sel_b),
        .i_op     (w_sel_op),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= REQ0;
            r_last_gnt  <= REQ1;
            r_ops_done  <= '0;
        end else begin
            if (w_drain) begin
                r_ops_done <= r_ops_done + CNT_W'(1);
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_id    <= w_gnt1 ? REQ1 : REQ0;
                r_last_gnt  <= w_gnt1 ? REQ1 : REQ0;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_id     = r_out_id;
    assign bus.ops_done   = r_ops_done;

endmodule : logic16_arbiter

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter: directed scenarios plus random
// traffic against a transaction-level model; a CNT_W=4 twin checks wrap.
module tb_logic16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, ordy;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  op0, op1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: result slot contents, arbitration history, consume count
    bit          m_valid;
    logic [15:0] m_data;
    int          m_id;
    int          m_last;
    int unsigned m_cnt;

    logic16_arbiter_if #(.CNT_W(16)) bus  ();
    logic16_arbiter_if #(.CNT_W(4))  bus4 ();

    logic16_arbiter #(.WIDTH(16), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic16_arbiter #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus4)
    );

    assign bus.req0_valid  = v0;   assign bus4.req0_valid = v0;
    assign bus.req0_a      = a0;   assign bus4.req0_a     = a0;
    assign bus.req0_b      = b0;   assign bus4.req0_b     = b0;
    assign bus.req0_op     = op0;  assign bus4.req0_op    = op0;
    assign bus.req1_valid  = v1;   assign bus4.req1_valid = v1;
    assign bus.req1_a      = a1;   assign bus4.req1_a     = a1;
    assign bus.req1_b      = b1;   assign bus4.req1_b     = b1;
    assign bus.req1_op     = op1;  assign bus4.req1_op    = op1;
    assign bus.out_ready   = ordy; assign bus4.out_ready  = ordy;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_last  = 1;
        m_cnt   = 0;
    endtask

    // Check all outputs against the model, clock once, advance the model.
    task automatic tick();
        bit free, g0, g1;
        #1;
        free = !m_valid || ordy;
        g0 = !rst && free && v0 && (!v1 || m_last != 0);
        g1 = !rst && free && v1 && (!v0 || m_last != 1);
        check_eq("req0_ready", 32'(bus.req0_ready), 32'(g0));
        check_eq("req1_ready", 32'(bus.req1_ready), 32'(g1));
        check_eq("out_valid",  32'(bus.out_valid),  32'(m_valid));
        check_eq("out_data",   32'(bus.out_data),   32'(m_data));
        check_eq("out_id",     32'(bus.out_id),     32'(m_id));
        check_eq("ops_done",   32'(bus.ops_done),   m_cnt % 65536);
        check_eq("ops_done4",  32'(bus4.ops_done),  m_cnt % 16);
        check_eq("ready4",     32'({bus4.req1_ready, bus4.req0_ready}), 32'({g1, g0}));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && ordy) m_cnt++;
            if (g0 || g1) begin
                m_valid = 1'b1;
                m_id    = g1 ? 1 : 0;
                m_last  = m_id;
                m_data  = g1 ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_data [4];
        logic [15:0] held;
        int unsigned cnt_before;
        exp_data[0] = 16'hF000;
        exp_data[1] = 16'hFFF0;
        exp_data[2] = 16'h0FF0;
        exp_data[3] = 16'h0FFF;

        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with valids asserted, then idle
        do_reset(2);
        v0 = 1'b0; v1 = 1'b0;
        tick();
        check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
        check_eq("idle_cnt",   32'(bus.ops_done),  32'd0);

        // Single requester, every opcode
        v0 = 1'b1; a0 = 16'hF0F0; b0 = 16'hFF00;
        for (int i = 0; i < 4; i++) begin
            op0 = 2'(i);
            tick();
            check_eq("op_data", 32'(bus.out_data), 32'(exp_data[i]));
            check_eq("op_id",   32'(bus.out_id),   32'd0);
        end
        v0 = 1'b0;
        tick();
        check_eq("op_cnt4", 32'(bus.ops_done), 32'd4);

        // Contention round-robin from reset
        do_reset(1);
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        a1 = 16'h1234; b1 = 16'h00FF; op1 = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rr_id", 32'(bus.out_id), 32'(i % 2));
        end

        // Backpressure: hold result, then drain+accept together
        v0 = 1'b0; v1 = 1'b1; ordy = 1'b0;
        tick();
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold", 32'(bus.out_data), 32'(held));
        end
        cnt_before = 32'(bus.ops_done);
        ordy = 1'b1;
        tick();
        check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
        check_eq("bp_cnt",   32'(bus.ops_done),  cnt_before + 1);
        check_eq("bp_id",    32'(bus.out_id),    32'd1);

        // Reset with a pending result
        ordy = 1'b0;
        tick();
        do_reset(1);
        check_eq("mr_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mr_cnt",   32'(bus.ops_done),  32'd0);
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        tick();
        check_eq("mr_first", 32'(bus.out_id), 32'd0);

        // 17 consumed results on the 4-bit counter
        do_reset(1);
        v0 = 1'b1; v1 = 1'b0; ordy = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        v0 = 1'b0;
        tick();
        check_eq("wrap4", 32'(bus4.ops_done), 32'd1);
        check_eq("wrap16", 32'(bus.ops_done), 32'd17);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst  = ($urandom_range(0, 79) == 0);
            v0   = ($urandom_range(0, 3) != 0);
            v1   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a0 = 16'($urandom); b0 = 16'($urandom); op0 = 2'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); op1 = 2'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_logic16_arbiter
